// File: rtl/actuator_pkg.sv
// Shared constants for the actuator controller: SPI frame layout, register
// addresses and the pulse-width reset value.
package actuator_pkg;

    localparam int FRAME_BITS = 24;
    localparam int DATA_BITS  = 16;
    localparam int ADDR_BITS  = 7;

    localparam logic [ADDR_BITS-1:0] ADDR_SHADOW      = 7'h00;
    localparam logic [ADDR_BITS-1:0] ADDR_ACTIVE      = 7'h01;
    localparam logic [ADDR_BITS-1:0] ADDR_PULSE_WIDTH = 7'h02;
    localparam logic [ADDR_BITS-1:0] ADDR_STATUS      = 7'h03;

    localparam logic [DATA_BITS-1:0] PULSE_RESET_DEFAULT = 16'd100;

endpackage

// File: rtl/actuator_spi_slave.sv
// Mode-0 SPI slave working on already-synchronized pins: 24-bit frames of
// {rw, addr[6:0], data[15:0]}, one-clock write strobe, MSB-first read data.
module actuator_spi_slave
    import actuator_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sclk,
    input  logic                 mosi,
    input  logic                 ss_n,
    input  logic [DATA_BITS-1:0] rd_data,
    output logic [ADDR_BITS-1:0] rd_addr,
    output logic                 miso,
    output logic                 wr_en,
    output logic [ADDR_BITS-1:0] wr_addr,
    output logic [DATA_BITS-1:0] wr_data
);

    localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);
    localparam logic [4:0] CNT_LAST = 5'(FRAME_BITS - 1);
    localparam logic [4:0] CNT_DATA = 5'(ADDR_BITS + 1);

    logic                  sclk_q;
    logic [FRAME_BITS-2:0] rx_sr;
    logic [4:0]            bit_cnt;
    logic [DATA_BITS-1:0]  tx_sr;
    logic                  sclk_rise;
    logic                  sclk_fall;

    assign sclk_rise = sclk & ~sclk_q;
    assign sclk_fall = ~sclk & sclk_q;

    // After the header bits the low bits of rx_sr hold the address being read.
    assign rd_addr = rx_sr[ADDR_BITS-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q  <= 1'b0;
            rx_sr   <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            miso    <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            sclk_q <= sclk;
            wr_en  <= 1'b0;
            if (ss_n) begin
                // Deselect discards any partial frame.
                bit_cnt <= '0;
                miso    <= 1'b0;
            end else begin
                if (sclk_rise && bit_cnt != CNT_FULL) begin
                    rx_sr   <= {rx_sr[FRAME_BITS-3:0], mosi};
                    bit_cnt <= bit_cnt + 5'd1;
                    if (bit_cnt == CNT_LAST) begin
                        wr_en   <= rx_sr[FRAME_BITS-2];
                        wr_addr <= rx_sr[FRAME_BITS-3 -: ADDR_BITS];
                        wr_data <= {rx_sr[DATA_BITS-2:0], mosi};
                    end
                end
                if (sclk_fall) begin
                    if (bit_cnt == CNT_DATA) begin
                        if (!rx_sr[ADDR_BITS]) begin
                            miso  <= rd_data[DATA_BITS-1];
                            tx_sr <= {rd_data[DATA_BITS-2:0], 1'b0};
                        end else begin
                            miso  <= 1'b0;
                            tx_sr <= '0;
                        end
                    end else if (bit_cnt > CNT_DATA && bit_cnt < CNT_FULL) begin
                        miso  <= tx_sr[DATA_BITS-1];
                        tx_sr <= {tx_sr[DATA_BITS-2:0], 1'b0};
                    end else begin
                        miso <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/actuator_controller.sv
// Actuator controller: SPI-configured shadow/active patterns and a timed,
// enable-gated drive pulse, with state mirrored on the logic-analyzer bus.
module actuator_controller
    import actuator_pkg::*;
#(
    parameter int             NUM_DRIVERS = 16,
    parameter logic [15:0]    PULSE_RESET = PULSE_RESET_DEFAULT,
    parameter int             SYNC_STAGES = 2
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   enable_n,
    input  logic                   trigger_in_n,
    input  logic                   latch_data_n,
    input  logic                   sclk,
    input  logic                   mosi,
    input  logic                   ss_n,
    output logic                   miso,
    output logic                   miso_oeb,
    output logic [NUM_DRIVERS-1:0] drive,
    output logic [31:0]            la_data_out
);

    logic [SYNC_STAGES-1:0] en_sync, trig_sync, latch_sync, ss_sync, sclk_sync, mosi_sync;
    logic                   trig_q, latch_q;

    // NOTE: non-blocking assignments make each stage take its neighbour's old value.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            en_sync    <= '1;
            trig_sync  <= '1;
            latch_sync <= '1;
            ss_sync    <= '1;
            sclk_sync  <= '0;
            mosi_sync  <= '0;
            trig_q     <= 1'b1;
            latch_q    <= 1'b1;
        end else begin
            en_sync    <= {en_sync[SYNC_STAGES-2:0], enable_n};
            trig_sync  <= {trig_sync[SYNC_STAGES-2:0], trigger_in_n};
            latch_sync <= {latch_sync[SYNC_STAGES-2:0], latch_data_n};
            ss_sync    <= {ss_sync[SYNC_STAGES-2:0], ss_n};
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            trig_q     <= trig_sync[SYNC_STAGES-1];
            latch_q    <= latch_sync[SYNC_STAGES-1];
        end
    end

    logic enable, trig_fall, latch_fall;
    assign enable     = ~en_sync[SYNC_STAGES-1];
    assign trig_fall  = trig_q & ~trig_sync[SYNC_STAGES-1];
    assign latch_fall = latch_q & ~latch_sync[SYNC_STAGES-1];
    assign miso_oeb   = ss_sync[SYNC_STAGES-1];

    logic [NUM_DRIVERS-1:0] shadow, active, active_next;
    logic [DATA_BITS-1:0]   pulse_width, counter, rd_data, wr_data;
    logic [ADDR_BITS-1:0]   rd_addr, wr_addr;
    logic                   busy, wr_en, start, do_latch;

    actuator_spi_slave u_spi (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .sclk    (sclk_sync[SYNC_STAGES-1]),
        .mosi    (mosi_sync[SYNC_STAGES-1]),
        .ss_n    (ss_sync[SYNC_STAGES-1]),
        .rd_data (rd_data),
        .rd_addr (rd_addr),
        .miso    (miso),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        rd_data = '0;
        case (rd_addr)
            ADDR_SHADOW:      rd_data = DATA_BITS'(shadow);
            ADDR_ACTIVE:      rd_data = DATA_BITS'(active);
            ADDR_PULSE_WIDTH: rd_data = pulse_width;
            ADDR_STATUS:      rd_data = {14'b0, enable, busy};
            default:          rd_data = '0;
        endcase
    end

    // A latch landing on the same clock as a trigger feeds the new pattern straight out.
    assign do_latch    = latch_fall & ~busy;
    assign active_next = do_latch ? shadow : active;
    assign start       = trig_fall & enable & ~busy & (pulse_width != '0);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            shadow      <= '0;
            active      <= '0;
            pulse_width <= PULSE_RESET;
            busy        <= 1'b0;
            counter     <= '0;
            drive       <= '0;
        end else begin
            active <= active_next;
            if (wr_en) begin
                case (wr_addr)
                    ADDR_SHADOW:      shadow      <= wr_data[NUM_DRIVERS-1:0];
                    ADDR_PULSE_WIDTH: pulse_width <= wr_data;
                    default:          ;
                endcase
            end
            if (start) begin
                busy    <= 1'b1;
                counter <= pulse_width;
                drive   <= active_next;
            end else if (busy && (!enable || counter == 16'd1)) begin
                busy    <= 1'b0;
                counter <= '0;
                drive   <= '0;
            end else if (busy) begin
                counter <= counter - 16'd1;
                drive   <= active;
            end else begin
                drive <= '0;
            end
        end
    end

    assign la_data_out = {14'b0, enable, busy, 16'(active)};

endmodule

// File: tb/tb_actuator_controller.sv
// Directed bench for actuator_controller: SPI register access, latch, timed
// pulse, abort and reset behaviour against hand-computed values.
module tb_actuator_controller;
    import actuator_pkg::*;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        enable_n, trigger_in_n, latch_data_n;
    logic        sclk, mosi, ss_n;
    logic        miso, miso_oeb;
    logic [15:0] drive;
    logic [31:0] la_data_out;

    int tests = 0;
    int fails = 0;
    logic [15:0] rx;

    actuator_controller dut (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_i     (wb_rst_i),
        .enable_n     (enable_n),
        .trigger_in_n (trigger_in_n),
        .latch_data_n (latch_data_n),
        .sclk         (sclk),
        .mosi         (mosi),
        .ss_n         (ss_n),
        .miso         (miso),
        .miso_oeb     (miso_oeb),
        .drive        (drive),
        .la_data_out  (la_data_out)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge wb_clk_i);
    endtask

    // sclk period 80 ns = 8 system clocks; miso sampled at each sclk rise.
    task automatic spi_xfer(input logic [23:0] frame, input int nbits, output logic [15:0] data);
        data = '0;
        ss_n = 1'b0;
        #80;
        for (int i = 0; i < nbits; i++) begin
            mosi = frame[23-i];
            #40 sclk = 1'b1;
            if (i >= 8) data = {data[14:0], miso};
            #40 sclk = 1'b0;
        end
        #80 ss_n = 1'b1;
        mosi = 1'b0;
        #80;
    endtask

    task automatic spi_write(input logic [6:0] addr, input logic [15:0] data);
        logic [15:0] dummy;
        spi_xfer({1'b1, addr, data}, 24, dummy);
    endtask

    task automatic spi_read(input logic [6:0] addr, output logic [15:0] data);
        spi_xfer({1'b0, addr, 16'h0000}, 24, data);
    endtask

    task automatic latch_pulse();
        latch_data_n = 1'b0;
        wait_clks(4);
        latch_data_n = 1'b1;
        wait_clks(4);
    endtask

    initial begin
        wb_rst_i     = 1'b1;
        enable_n     = 1'b1;
        trigger_in_n = 1'b1;
        latch_data_n = 1'b1;
        sclk         = 1'b0;
        mosi         = 1'b0;
        ss_n         = 1'b1;
        wait_clks(3);
        check("rst_drive", 32'(drive), 32'h0);
        check("rst_la", la_data_out, 32'h0);
        check("rst_miso_oeb", 32'(miso_oeb), 32'h1);
        check("rst_miso", 32'(miso), 32'h0);
        wb_rst_i = 1'b0;
        wait_clks(4);

        spi_read(ADDR_PULSE_WIDTH, rx);
        check("rd_pw_reset", 32'(rx), 32'h0064);

        // Shadow write, latch, and read back through ACTIVE.
        spi_write(ADDR_SHADOW, 16'hA5C3);
        check("active_before_latch", 32'(la_data_out[15:0]), 32'h0);
        latch_pulse();
        check("la_active_latched", 32'(la_data_out[15:0]), 32'hA5C3);
        spi_read(ADDR_ACTIVE, rx);
        check("rd_active", 32'(rx), 32'hA5C3);
        spi_read(ADDR_SHADOW, rx);
        check("rd_shadow", 32'(rx), 32'hA5C3);

        // 5-cycle pulse with a retrigger edge landing mid-pulse.
        spi_write(ADDR_PULSE_WIDTH, 16'd5);
        enable_n = 1'b0;
        wait_clks(4);
        check("la_enable", 32'(la_data_out[17]), 32'h1);
        trigger_in_n = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            @(negedge wb_clk_i);
            check($sformatf("pulse5_drive_%0d", n), 32'(drive),
                  (n >= 3 && n <= 7) ? 32'hA5C3 : 32'h0);
            if (n == 3) check("pulse5_busy", 32'(la_data_out[16]), 32'h1);
            if (n == 1) trigger_in_n = 1'b1;
            if (n == 2) trigger_in_n = 1'b0;
        end
        trigger_in_n = 1'b1;
        wait_clks(3);
        check("pulse5_busy_end", 32'(la_data_out[16]), 32'h0);
        spi_read(ADDR_STATUS, rx);
        check("rd_status_en", 32'(rx), 32'h0002);

        // Enable drops at pulse cycle 2 of 10: pulse aborts.
        spi_write(ADDR_PULSE_WIDTH, 16'd10);
        trigger_in_n = 1'b0;
        wait_clks(4);
        check("abort_cycle2", 32'(drive), 32'hA5C3);
        enable_n = 1'b1;
        wait_clks(2);
        check("abort_sync_delay", 32'(drive), 32'hA5C3);
        wait_clks(1);
        check("abort_drive", 32'(drive), 32'h0);
        check("abort_busy", 32'(la_data_out[16]), 32'h0);
        trigger_in_n = 1'b1;
        wait_clks(3);

        // Trigger with enable off.
        trigger_in_n = 1'b0;
        wait_clks(6);
        check("noen_drive", 32'(drive), 32'h0);
        check("noen_busy", 32'(la_data_out[16]), 32'h0);
        trigger_in_n = 1'b1;
        wait_clks(3);

        // Aborted frame, unmapped address, read-only address.
        spi_xfer({1'b1, ADDR_SHADOW, 16'hFFFF}, 12, rx);
        spi_read(ADDR_SHADOW, rx);
        check("short_frame", 32'(rx), 32'hA5C3);
        spi_write(7'h7F, 16'h1234);
        spi_read(7'h7F, rx);
        check("rd_unmapped", 32'(rx), 32'h0);
        spi_write(ADDR_ACTIVE, 16'h0000);
        check("ro_active", 32'(la_data_out[15:0]), 32'hA5C3);
        spi_read(ADDR_STATUS, rx);
        check("rd_status_dis", 32'(rx), 32'h0000);

        // Zero pulse width ignores triggers.
        enable_n = 1'b0;
        spi_write(ADDR_PULSE_WIDTH, 16'd0);
        trigger_in_n = 1'b0;
        wait_clks(6);
        check("pw0_busy", 32'(la_data_out[16]), 32'h0);
        check("pw0_drive", 32'(drive), 32'h0);
        trigger_in_n = 1'b1;
        wait_clks(3);

        // Latch while busy is ignored.
        spi_write(ADDR_SHADOW, 16'h1234);
        spi_write(ADDR_PULSE_WIDTH, 16'd10);
        trigger_in_n = 1'b0;
        wait_clks(4);
        latch_data_n = 1'b0;
        wait_clks(3);
        check("busy_latch_active", 32'(la_data_out[15:0]), 32'hA5C3);
        check("busy_latch_drive", 32'(drive), 32'hA5C3);
        latch_data_n = 1'b1;
        wait_clks(10);
        check("busy_latch_end", 32'(la_data_out[16]), 32'h0);
        trigger_in_n = 1'b1;
        wait_clks(3);

        // Simultaneous trigger and latch while idle: pulse carries new pattern.
        trigger_in_n = 1'b0;
        latch_data_n = 1'b0;
        wait_clks(2);
        check("simul_pre", 32'(drive), 32'h0);
        wait_clks(1);
        check("simul_drive", 32'(drive), 32'h1234);
        check("simul_active", 32'(la_data_out[15:0]), 32'h1234);
        trigger_in_n = 1'b1;
        latch_data_n = 1'b1;
        wait_clks(3);

        // Reset in the middle of a pulse.
        trigger_in_n = 1'b0;
        wait_clks(5);
        check("pre_rst_busy", 32'(la_data_out[16]), 32'h1);
        wb_rst_i = 1'b1;
        #1;
        check("midrst_drive", 32'(drive), 32'h0);
        check("midrst_la", la_data_out, 32'h0);
        check("midrst_oeb", 32'(miso_oeb), 32'h1);
        trigger_in_n = 1'b1;
        wait_clks(2);
        wb_rst_i = 1'b0;
        wait_clks(4);
        spi_read(ADDR_PULSE_WIDTH, rx);
        check("post_rst_pw", 32'(rx), 32'h0064);
        spi_read(ADDR_SHADOW, rx);
        check("post_rst_shadow", 32'(rx), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/actuator_controller.md
Name: actuator_controller

Overview:
- User-project core behind the management SoC.
- Accepts configuration over a 4-wire SPI slave (sclk, mosi, ss_n, miso), holds a shadow and an active actuator pattern, and fires a timed drive pulse on trigger_in_n when enabled.
- Active pattern and status are mirrored onto the logic-analyzer bus for firmware inspection.
- All external pins are asynchronous to wb_clk_i and are synchronized inside.

Parameters:
- NUM_DRIVERS, 16, width of pattern registers and drive output.
- PULSE_RESET, 16'd100, reset value of PULSE_WIDTH register (clocks).
- SYNC_STAGES, 2, synchronizer flops per async input.

Ports:
- wb_clk_i  in  1  system clock; one clock, all logic on rising edge.
- wb_rst_i  in  1  reset; asynchronous, active-high.
- enable_n  in  1  active-low output enable (async pin).
- trigger_in_n  in  1  active-low pulse trigger (async pin).
- latch_data_n  in  1  active-low copy shadow->active (async pin).
- sclk  in  1  SPI clock, mode 0, ≤ wb_clk_i/4.
- mosi  in  1  SPI data in, MSB first.
- ss_n  in  1  SPI select, active low.
- miso  out  1  SPI data out.
- miso_oeb  out  1  pad output-enable, low = drive; equals synchronized ss_n.
- drive  out  NUM_DRIVERS  actuator outputs.
- la_data_out  out  32  [15:0] ACTIVE, [16] busy, [17] enable (synced ~enable_n), [31:18] 0.

Behaviour:
- Reset: SHADOW=0, ACTIVE=0, PULSE_WIDTH=PULSE_RESET, busy=0, counter=0, drive=0, miso=0, miso_oeb=1, SPI bit counter=0. Synchronizers reset to inactive (1 for _n pins and ss_n, 0 for sclk).
- Sync: every async input passes SYNC_STAGES flops; edges are detected on synchronized values.
- SPI frame = 24 bits: [23] R/W (1=write), [22:16] addr, [15:0] data. mosi sampled on synced sclk rising edge; miso updated on synced sclk falling edge.
- SPI write commits on the 24th sampled bit.
- SPI read: miso shifts register bits 15..0 during data phase; miso=0 otherwise.
- ss_n rising before 24 bits: frame discarded, no write. Bits beyond 24: ignored. ss_n falling: bit counter cleared.
- Register map:
  - 0x00 SHADOW RW.
  - 0x01 ACTIVE RO.
  - 0x02 PULSE_WIDTH RW.
  - 0x03 STATUS RO ({14'b0, enable, busy}).
  - Others read 0; writes ignored. Writes to RO addresses are ignored.
- Latch: falling edge of synced latch_data_n copies SHADOW->ACTIVE next clock. Ignored while busy, so drive is glitch-free.
- Pulse: falling edge of synced trigger_in_n with enable active, busy=0 and PULSE_WIDTH≠0 sets busy=1 and counter=PULSE_WIDTH. Counter decrements each clock; busy clears when counter reaches 1 is consumed, giving exactly PULSE_WIDTH cycles high.
- drive = ACTIVE when busy and enable, else 0, registered. Drive rises 3 clocks after the trigger pin falls (2 sync + 1 register).
- PULSE_WIDTH=0: trigger ignored. Retrigger while busy: ignored.
- enable_n deasserted mid-pulse: drive=0 next clock, busy cleared (pulse aborted).
- Simultaneous trigger and latch edges while idle: the latch takes effect the same clock, and the pulse uses the new ACTIVE.
- SPI write to PULSE_WIDTH while busy: stored, applies to the next pulse only.
- Reset mid-operation: all state returns to reset values immediately; any partial SPI frame is discarded.

Decomposition:
- Package actuator_pkg: register address constants (ADDR_SHADOW..ADDR_STATUS), FRAME_BITS=24, DATA_BITS=16, PULSE_RESET default.
- One sub-module: actuator_spi_slave. Covers sclk/ss_n edge detect, shift registers, frame counter, and write strobe with addr/data plus read-data mux input.
- Synchronizers stay inline.

Test Plan:
- Reset: assert wb_rst_i mid-run -> drive=0, la_data_out=0, miso_oeb=1. SPI read of 0x02 after reset returns 0x0064.
- SPI write 0x00=0xA5C3, pulse latch_data_n low -> la_data_out[15:0]=0xA5C3. SPI read 0x01 returns 0xA5C3 on miso.
- PULSE_WIDTH=5, enable_n=0, trigger_in_n falls -> drive=0xA5C3 exactly 5 clocks starting 3 clocks later. Second trigger during pulse -> no extension.
- enable_n rises at pulse cycle 2 of 10 -> drive=0 next clock, busy=0. enable_n=1 at trigger -> drive stays 0.
- SPI abort: ss_n high after 12 bits of write 0x00=0xFFFF -> SHADOW unchanged. Write to 0x7F then read 0x7F -> reads 0.
- PULSE_WIDTH=0 with trigger -> no pulse, busy stays 0. Latch during busy -> ACTIVE unchanged.
